// File: rtl/mar_access_unit_if.sv
// Bus between the control store / address adder and the MAR access unit.
// master drives the select, address and handshake inputs; slave is the unit itself.
interface mar_access_unit_if #(
    parameter int ADDR_W = 16,
    parameter int VEC_W  = 8
);
    logic              i_MarMuxControl;
    logic [VEC_W-1:0]  i_IR_Vec;
    logic [ADDR_W-1:0] i_Address;
    logic              i_LdMar;
    logic              i_MemEn;
    logic              i_RW;
    logic              i_MemReady;
    logic [ADDR_W-1:0] o_MarMux;
    logic [ADDR_W-1:0] o_Mar;
    logic              o_MemReq;
    logic              o_MemWe;
    logic              o_R;
    logic              o_Busy;
    logic              o_Timeout;

    modport master (
        output i_MarMuxControl, i_IR_Vec, i_Address, i_LdMar, i_MemEn, i_RW, i_MemReady,
        input  o_MarMux, o_Mar, o_MemReq, o_MemWe, o_R, o_Busy, o_Timeout
    );

    modport slave (
        input  i_MarMuxControl, i_IR_Vec, i_Address, i_LdMar, i_MemEn, i_RW, i_MemReady,
        output o_MarMux, o_Mar, o_MemReq, o_MemWe, o_R, o_Busy, o_Timeout
    );
endinterface

// File: rtl/mar_access_unit.sv
// MARMUX address select, MAR register and memory-access sequencer returning the R bit.
// Optional MAR_TIMEOUT_EN: bounded wait in REQ, falling into ERR with o_Timeout.
module mar_access_unit #(
    parameter int ADDR_W   = 16,
    parameter int VEC_W    = 8,
    parameter int CNT_W    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    mar_access_unit_if.slave     bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE, ST_ERR} state_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] vec_ext;
    logic [ADDR_W-1:0] mar_mux;
    logic [ADDR_W-1:0] mar_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              rw_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic              busy_reg;
    logic              r_reg;
    logic              timeout_reg;

    // Zero-extend the trap vector bit by bit.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_vec_ext
            if (gi < VEC_W) begin : g_vec_bit
                assign vec_ext[gi] = bus.i_IR_Vec[gi];
            end else begin : g_zero_bit
                assign vec_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign mar_mux = bus.i_MarMuxControl ? vec_ext : bus.i_Address;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.i_MemEn) state_next = ST_REQ;
            ST_REQ: begin
                if (bus.i_MemReady) state_next = ST_DONE;
`ifdef MAR_TIMEOUT_EN
                else if (cnt_reg == WAIT_LIM) state_next = ST_ERR;
`endif
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR: begin
`ifdef MAR_TIMEOUT_EN
                if (!bus.i_MemEn) state_next = ST_IDLE;
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg   <= ST_IDLE;
            mar_reg     <= '0;
            cnt_reg     <= '0;
            rw_reg      <= 1'b0;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            r_reg       <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (bus.i_LdMar && (state_reg == ST_IDLE || state_reg == ST_DONE))
                mar_reg <= mar_mux;
            if (state_reg == ST_IDLE && bus.i_MemEn) begin
                rw_reg  <= bus.i_RW;
                cnt_reg <= '0;
            end else if (state_reg == ST_REQ && !bus.i_MemReady && cnt_reg != WAIT_LIM) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            mem_req_reg <= (state_next == ST_REQ);
            busy_reg    <= (state_next == ST_REQ);
            mem_we_reg  <= (state_next == ST_REQ) &&
                           ((state_reg == ST_IDLE) ? bus.i_RW : rw_reg);
            r_reg       <= (state_next == ST_DONE);
            timeout_reg <= (state_next == ST_ERR);
        end
    end

    assign bus.o_MarMux  = mar_mux;
    assign bus.o_Mar     = mar_reg;
    assign bus.o_MemReq  = mem_req_reg;
    assign bus.o_MemWe   = mem_we_reg;
    assign bus.o_Busy    = busy_reg;
    assign bus.o_R       = r_reg;
    assign bus.o_Timeout = timeout_reg;
endmodule
